// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory-stage controller: byte/half/word access over a req/ack bus with timeout
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  ex_en,
  input  logic [3:0]                            ex_mem_op,
  input  logic [DATA_W-1:0]                     ex_mem_wr_data,
  input  logic [ADDR_W+$clog2(DATA_W/8)-1:0]    ex_out,
  output logic                                  bus_req,
  output logic [ADDR_W-1:0]                     bus_addr,
  output logic                                  bus_rw,
  output logic [DATA_W-1:0]                     bus_wr_data,
  output logic [DATA_W/8-1:0]                   bus_be,
  input  logic [DATA_W-1:0]                     bus_rd_data,
  input  logic                                  bus_ack,
  output logic [DATA_W-1:0]                     out,
  output logic                                  busy,
  output logic                                  miss_align,
  output logic                                  bus_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int EX_W  = ADDR_W + OFF_W;
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [BE_W-1:0] BE_BYTE0 = {1'b1, {(BE_W-1){1'b0}}};
  localparam logic [BE_W-1:0] BE_HALF0 = {2'b11, {(BE_W-2){1'b0}}};

  localparam logic [3:0] OP_LDW  = 4'd1;
  localparam logic [3:0] OP_STW  = 4'd2;
  localparam logic [3:0] OP_LDH  = 4'd3;
  localparam logic [3:0] OP_LDHU = 4'd4;
  localparam logic [3:0] OP_LDB  = 4'd5;
  localparam logic [3:0] OP_LDBU = 4'd6;
  localparam logic [3:0] OP_STH  = 4'd7;
  localparam logic [3:0] OP_STB  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  state_t state, state_nx;

  logic [3:0]        op_q;
  logic [OFF_W-1:0]  off_q;
  logic [15:0]       wait_cnt;
  logic [DATA_W-1:0] out_q;
  logic              req_q, err_q, rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;

  logic [OFF_W-1:0]  ex_off;
  logic              is_word, is_half, is_byte, is_store, is_mem, aligned, accept;
  logic [BE_W-1:0]   ex_be;
  logic [DATA_W-1:0] ex_wdata;
  logic [DATA_W-1:0] ex_ext;
  logic              timed_out;

  assign ex_off    = ex_out[OFF_W-1:0];
  assign ex_ext    = DATA_W'(ex_out);
  assign accept    = ex_en && is_mem && aligned;
  assign timed_out = (wait_cnt == TO_LAST);

  always_comb begin
    is_word  = (ex_mem_op == OP_LDW) || (ex_mem_op == OP_STW);
    is_half  = (ex_mem_op == OP_LDH) || (ex_mem_op == OP_LDHU) || (ex_mem_op == OP_STH);
    is_byte  = (ex_mem_op == OP_LDB) || (ex_mem_op == OP_LDBU) || (ex_mem_op == OP_STB);
    is_store = (ex_mem_op == OP_STW) || (ex_mem_op == OP_STH) || (ex_mem_op == OP_STB);
    is_mem   = is_word || is_half || is_byte;
    // Offset 0 is the most significant lane, so enables shift right with the offset.
    if (is_word) begin
      aligned  = (ex_off == '0);
      ex_be    = '1;
      ex_wdata = ex_mem_wr_data;
    end else if (is_half) begin
      aligned  = !ex_off[0];
      ex_be    = BE_HALF0 >> ex_off;
      ex_wdata = {(DATA_W/16){ex_mem_wr_data[15:0]}};
    end else begin
      aligned  = 1'b1;
      ex_be    = BE_BYTE0 >> ex_off;
      ex_wdata = {BE_W{ex_mem_wr_data[7:0]}};
    end
  end

  logic [IDX_W-1:0]  byte_lsb, half_lsb;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [DATA_W-1:0] load_val;

  always_comb begin
    byte_lsb = IDX_W'(DATA_W - 8)  - {off_q, 3'b000};
    half_lsb = IDX_W'(DATA_W - 16) - {off_q[OFF_W-1:1], 4'b0000};
    lane_b   = bus_rd_data[byte_lsb +: 8];
    lane_h   = bus_rd_data[half_lsb +: 16];
    case (op_q)
      OP_LDH:  load_val = {{(DATA_W-16){lane_h[15]}}, lane_h};
      OP_LDHU: load_val = {{(DATA_W-16){1'b0}}, lane_h};
      OP_LDB:  load_val = {{(DATA_W-8){lane_b[7]}}, lane_b};
      OP_LDBU: load_val = {{(DATA_W-8){1'b0}}, lane_b};
      default: load_val = bus_rd_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b0;
    miss_align = 1'b0;
    out        = '0;
    case (state)
      S_IDLE: begin
        if (ex_en && !is_mem) begin
          out = ex_ext;
        end else if (ex_en && !aligned) begin
          miss_align = 1'b1;
        end else if (accept) begin
          busy     = 1'b1;
          state_nx = S_ACCESS;
        end
      end
      S_ACCESS: begin
        busy = 1'b1;
        if (bus_ack || timed_out) state_nx = S_DONE;
      end
      S_DONE: begin
        out      = out_q;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      off_q    <= '0;
      wait_cnt <= '0;
      out_q    <= '0;
      req_q    <= 1'b0;
      err_q    <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= ex_mem_op;
            off_q    <= ex_off;
            addr_q   <= ex_out[EX_W-1:OFF_W];
            be_q     <= ex_be;
            rw_q     <= is_store;
            wdata_q  <= is_store ? ex_wdata : '0;
            req_q    <= 1'b1;
            wait_cnt <= '0;
            out_q    <= '0;
          end
        end
        S_ACCESS: begin
          // An ack on the final wait cycle takes priority over the timeout.
          if (bus_ack) begin
            req_q <= 1'b0;
            out_q <= rw_q ? '0 : load_val;
          end else if (timed_out) begin
            req_q <= 1'b0;
            err_q <= 1'b1;
            out_q <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: err_q <= 1'b0;
      endcase
    end
  end

  assign bus_req     = req_q;
  assign bus_addr    = addr_q;
  assign bus_rw      = rw_q;
  assign bus_be      = be_q;
  assign bus_wr_data = wdata_q;
  assign bus_err     = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_en;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data;
  logic [31:0] ex_out;
  logic        bus_req;
  logic [29:0] bus_addr;
  logic        bus_rw;
  logic [31:0] bus_wr_data;
  logic [3:0]  bus_be;
  logic [31:0] bus_rd_data;
  logic        bus_ack;
  logic [31:0] out;
  logic        busy;
  logic        miss_align;
  logic        bus_err;

  mem_access_unit #(.DATA_W(32), .ADDR_W(30), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .ex_en(ex_en), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_out(ex_out), .bus_req(bus_req),
    .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_wr_data(bus_wr_data),
    .bus_be(bus_be), .bus_rd_data(bus_rd_data), .bus_ack(bus_ack), .out(out),
    .busy(busy), .miss_align(miss_align), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic        chk = 1'b0, chk_out, chk_bus, chk_wd;
  logic        exp_busy, exp_req, exp_err, exp_miss, exp_rw;
  logic [31:0] exp_out, exp_wd;
  logic [29:0] exp_addr;
  logic [3:0]  exp_be;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: access size in bytes, lanes counted from the MSB.
  function automatic bit m_is_mem(input int op);
    return op >= 1 && op <= 8;
  endfunction
  function automatic bit m_is_store(input int op);
    return op == 2 || op == 7 || op == 8;
  endfunction
  function automatic int m_size(input int op);
    if (op == 1 || op == 2) return 4;
    if (op == 3 || op == 4 || op == 7) return 2;
    return 1;
  endfunction
  function automatic bit m_aligned(input int op, input int off);
    return (off % m_size(op)) == 0;
  endfunction
  function automatic logic [3:0] m_be(input int op, input int off);
    logic [3:0] be = 4'b0000;
    for (int b = off; b < off + m_size(op); b++) be = be | (4'b1000 >> b);
    return be;
  endfunction
  function automatic logic [31:0] m_wdata(input int op, input logic [31:0] wd);
    if (m_size(op) == 4) return wd;
    if (m_size(op) == 2) return {2{wd[15:0]}};
    return {4{wd[7:0]}};
  endfunction
  function automatic logic [31:0] m_load(input int op, input int off, input logic [31:0] rd);
    logic [31:0] v;
    int sz = m_size(op);
    v = rd >> (8 * (4 - off - sz));
    if (sz == 2) begin
      v = v & 32'h0000FFFF;
      if (op == 3 && v[15]) v = v | 32'hFFFF0000;
    end else if (sz == 1) begin
      v = v & 32'h000000FF;
      if (op == 5 && v[7]) v = v | 32'hFFFFFF00;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      check("busy", 64'(busy), 64'(exp_busy));
      check("bus_req", 64'(bus_req), 64'(exp_req));
      check("bus_err", 64'(bus_err), 64'(exp_err));
      check("miss_align", 64'(miss_align), 64'(exp_miss));
      if (chk_out) check("out", 64'(out), 64'(exp_out));
      if (chk_bus) begin
        check("bus_addr", 64'(bus_addr), 64'(exp_addr));
        check("bus_rw", 64'(bus_rw), 64'(exp_rw));
        check("bus_be", 64'(bus_be), 64'(exp_be));
      end
      if (chk_wd) check("bus_wr_data", 64'(bus_wr_data), 64'(exp_wd));
    end
  end

  task automatic set_quiet(input logic [31:0] o);
    exp_busy = 0; exp_req = 0; exp_err = 0; exp_miss = 0;
    chk_out = 1; exp_out = o; chk_bus = 0; chk_wd = 0;
  endtask

  task automatic run_txn(input bit en, input int op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rd, input int ack_at,
                         input bit use_lit, input logic [3:0] lit_be,
                         input logic [31:0] lit_wd, input logic [31:0] lit_out);
    int off, k;
    bit acc, done;
    off = int'(addr[1:0]);
    acc = en && m_is_mem(op) && m_aligned(op, off);
    @(posedge clk); #1;
    ex_en = en; ex_mem_op = op[3:0]; ex_out = addr; ex_mem_wr_data = wd; bus_ack = 0;
    set_quiet((en && !m_is_mem(op)) ? addr : 32'h0);
    exp_busy = acc;
    exp_miss = en && m_is_mem(op) && !m_aligned(op, off);
    chk_out  = !acc;
    if (acc) begin
      k = 0; done = 0;
      while (!done) begin
        k++;
        @(posedge clk); #1;
        ex_mem_op = 4'($urandom_range(0, 15)); ex_out = $urandom; ex_mem_wr_data = $urandom;
        bus_ack = (k == ack_at);
        bus_rd_data = bus_ack ? rd : $urandom;
        exp_busy = 1; exp_req = 1; exp_err = 0; exp_miss = 0; chk_out = 0;
        chk_bus = 1; exp_addr = addr[31:2]; exp_rw = m_is_store(op); exp_be = m_be(op, off);
        chk_wd = m_is_store(op); exp_wd = m_wdata(op, wd);
        done = bus_ack || k == TO;
        if (use_lit && k == 1) begin
          @(negedge clk);
          check("lit_be", 64'(bus_be), 64'(lit_be));
          if (m_is_store(op)) check("lit_wd", 64'(bus_wr_data), 64'(lit_wd));
        end
      end
      @(posedge clk); #1;
      bus_ack = 1; bus_rd_data = $urandom; ex_en = 1; ex_mem_op = 4'd1; ex_out = 32'h200;
      set_quiet((k == ack_at && !m_is_store(op)) ? m_load(op, off, rd) : 32'h0);
      exp_err = (k != ack_at);
      if (use_lit) begin
        @(negedge clk);
        check("lit_out", 64'(out), 64'(lit_out));
      end
    end
    @(posedge clk); #1;
    ex_en = 0; ex_mem_op = 0; bus_ack = 0;
    set_quiet(32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; ex_en = 0; ex_mem_op = 0; ex_mem_wr_data = 0; ex_out = 0;
    bus_rd_data = 0; bus_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    set_quiet(32'h0);
    chk_bus = 1; exp_addr = 0; exp_rw = 0; exp_be = 0; chk_wd = 1; exp_wd = 0;
    chk = 1;
    @(posedge clk); #1;
    reset = 0;
    set_quiet(32'h0);

    run_txn(1, 0,  32'h0000_1234, 0, 0, 0, 0, 0, 0, 0);
    run_txn(1, 12, 32'h0000_ABCD, 0, 0, 0, 0, 0, 0, 0);
    run_txn(0, 1,  32'h0000_0100, 0, 0, 1, 0, 0, 0, 0);
    run_txn(1, 5, 32'h101, 0, 32'h11F2_3344, 3, 1, 4'b0100, 0, 32'hFFFF_FFF2);
    run_txn(1, 6, 32'h101, 0, 32'h11F2_3344, 3, 1, 4'b0100, 0, 32'h0000_00F2);
    run_txn(1, 7, 32'h202, 32'h0000_BEEF, 0, 1, 1, 4'b0011, 32'hBEEF_BEEF, 32'h0);
    run_txn(1, 1, 32'h103, 0, 0, 1, 0, 0, 0, 0);
    run_txn(1, 3, 32'h101, 0, 0, 1, 0, 0, 0, 0);
    run_txn(1, 2, 32'h102, 32'h1, 0, 1, 0, 0, 0, 0);
    run_txn(1, 1, 32'h100, 0, 32'h5555_AAAA, 0, 1, 4'b1111, 0, 32'h0);
    run_txn(1, 1, 32'h100, 0, 32'h89AB_CDEF, 4, 1, 4'b1111, 0, 32'h89AB_CDEF);
    run_txn(1, 3, 32'h102, 0, 32'h1234_8765, 2, 1, 4'b0011, 0, 32'hFFFF_8765);
    run_txn(1, 4, 32'h100, 0, 32'h8000_1234, 1, 1, 4'b1100, 0, 32'h0000_8000);
    run_txn(1, 8, 32'h003, 32'h0000_005A, 0, 2, 1, 4'b0001, 32'h5A5A_5A5A, 32'h0);
    run_txn(1, 2, 32'h040, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0);

    // Reset while an access is waiting for ack.
    @(posedge clk); #1;
    ex_en = 1; ex_mem_op = 4'd1; ex_out = 32'h100; bus_ack = 0;
    set_quiet(32'h0); exp_busy = 1; chk_out = 0;
    @(posedge clk); #1;
    ex_en = 0;
    exp_busy = 1; exp_req = 1; chk_bus = 1; exp_addr = 30'h40; exp_rw = 0; exp_be = 4'b1111;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0; bus_ack = 1; bus_rd_data = 32'h1111_1111;
    set_quiet(32'h0);
    chk_bus = 1; exp_addr = 0; exp_rw = 0; exp_be = 0;
    @(posedge clk); #1;
    bus_ack = 0;
    set_quiet(32'h0);
    run_txn(1, 1, 32'h100, 0, 32'hCAFE_F00D, 2, 1, 4'b1111, 0, 32'hCAFE_F00D);

    @(posedge clk); #1;
    chk = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
